// File: rtl/interrupt_controller_if.sv
// Bus, source and CPU handshake bundle for the interrupt controller.
`timescale 1ns/1ps
interface interrupt_controller_if;
  logic [7:0] src;
  logic [7:0] din;
  logic [7:0] address;
  logic       w_en;
  logic       r_en;
  logic [7:0] dout;
  logic       irq;
  logic [2:0] irq_vector;
  logic       int_ack;

  modport master (
    output src, din, address, w_en, r_en, int_ack,
    input  dout, irq, irq_vector
  );

  modport slave (
    input  src, din, address, w_en, r_en, int_ack,
    output dout, irq, irq_vector
  );
endinterface

// File: rtl/interrupt_controller.sv
// 8-source edge-capturing interrupt controller with memory-mapped registers
// and a request/acknowledge/end-of-interrupt handshake to the CPU.
`timescale 1ns/1ps
module interrupt_controller #(
  parameter logic [7:0] INT_CTRL_ADDRESS = 8'h10
) (
  input logic             clk,
  input logic             rst,
  interrupt_controller_if.slave bus
);

  localparam int unsigned NSRC = 8;
  localparam int unsigned VW   = 3;

  localparam logic [7:0] ADDR_ENABLE  = INT_CTRL_ADDRESS;
  localparam logic [7:0] ADDR_PENDING = INT_CTRL_ADDRESS + 8'd1;
  localparam logic [7:0] ADDR_CONTROL = INT_CTRL_ADDRESS + 8'd2;
  localparam logic [7:0] ADDR_STATUS  = INT_CTRL_ADDRESS + 8'd3;
  localparam logic [7:0] ADDR_EOI     = INT_CTRL_ADDRESS + 8'd4;
  localparam logic [7:0] ADDR_SWSET   = INT_CTRL_ADDRESS + 8'd5;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

  state_t          state, state_d;
  logic [NSRC-1:0] src_q, pending, pending_d, enable;
  logic            gie;
  logic            irq, irq_d;
  logic [VW-1:0]   irq_vector, vec_d, sel;
  logic [7:0]      dout, rd_data;

  logic [NSRC-1:0] rise, active, ack_mask, w1c_mask, swset_mask;
  logic            wr_enable, wr_pending, wr_control, wr_eoi, wr_swset;
  logic            ack_take;

  assign wr_enable  = bus.w_en && (bus.address == ADDR_ENABLE);
  assign wr_pending = bus.w_en && (bus.address == ADDR_PENDING);
  assign wr_control = bus.w_en && (bus.address == ADDR_CONTROL);
  assign wr_eoi     = bus.w_en && (bus.address == ADDR_EOI);
  assign wr_swset   = bus.w_en && (bus.address == ADDR_SWSET);

  assign rise   = bus.src & ~src_q;
  assign active = gie ? (pending & enable) : '0;

  // Lowest set bit of active wins
  always_comb begin
    sel = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (active[i]) sel = VW'(i);
    end
  end

  // Acknowledge clears the serviced bit; new rises and software sets still win
  assign ack_take   = (state == REQ) && bus.int_ack && (active != '0);
  assign ack_mask   = ack_take ? (NSRC'(1) << sel) : '0;
  assign w1c_mask   = (wr_pending ? bus.din : '0) | ack_mask;
  assign swset_mask = wr_swset ? bus.din : '0;
  assign pending_d  = (pending & ~w1c_mask) | rise | swset_mask;

  always_comb begin
    state_d = state;
    irq_d   = irq;
    vec_d   = irq_vector;
    case (state)
      IDLE: begin
        irq_d = 1'b0;
        if (active != '0) begin
          state_d = REQ;
          irq_d   = 1'b1;
          vec_d   = sel;
        end
      end
      REQ: begin
        irq_d = 1'b1;
        vec_d = sel;
        if (ack_take) begin
          state_d = SERVICE;
          irq_d   = 1'b0;
        end else if (active == '0) begin
          state_d = IDLE;
          irq_d   = 1'b0;
          vec_d   = irq_vector;
        end
      end
      SERVICE: begin
        irq_d = 1'b0;
        if (wr_eoi) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        irq_d   = 1'b0;
      end
    endcase
  end

  always_comb begin
    rd_data = '0;
    case (bus.address)
      ADDR_ENABLE:  rd_data = enable;
      ADDR_PENDING: rd_data = pending;
      ADDR_CONTROL: rd_data = {7'b0, gie};
      ADDR_STATUS:  rd_data = {irq, 2'b00, irq_vector, state};
      default:      rd_data = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      irq        <= 1'b0;
      irq_vector <= '0;
      src_q      <= '0;
      pending    <= '0;
      enable     <= '0;
      gie        <= 1'b0;
      dout       <= '0;
    end else begin
      state      <= state_d;
      irq        <= irq_d;
      irq_vector <= vec_d;
      src_q      <= bus.src;
      pending    <= pending_d;
      if (wr_enable)  enable <= bus.din;
      if (wr_control) gie    <= bus.din[0];
      if (bus.r_en)   dout   <= rd_data;
    end
  end

  assign bus.dout       = dout;
  assign bus.irq        = irq;
  assign bus.irq_vector = irq_vector;

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed self-checking bench for interrupt_controller.
`timescale 1ns/1ps
module tb_interrupt_controller;

  localparam logic [7:0] BASE = 8'h10;
  localparam logic [7:0] A_EN = BASE + 8'd0;
  localparam logic [7:0] A_PD = BASE + 8'd1;
  localparam logic [7:0] A_CT = BASE + 8'd2;
  localparam logic [7:0] A_ST = BASE + 8'd3;
  localparam logic [7:0] A_EO = BASE + 8'd4;
  localparam logic [7:0] A_SW = BASE + 8'd5;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;
  logic [7:0] rd;

  interrupt_controller_if bus_if ();

  interrupt_controller #(.INT_CTRL_ADDRESS(BASE)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
    bus_if.address = a;
    bus_if.din     = d;
    bus_if.w_en    = 1'b1;
    tick();
    bus_if.w_en    = 1'b0;
  endtask

  task automatic bus_read(input logic [7:0] a, output logic [7:0] d);
    bus_if.address = a;
    bus_if.r_en    = 1'b1;
    tick();
    bus_if.r_en    = 1'b0;
    d = bus_if.dout;
  endtask

  task automatic check_irq(input string tag, input logic exp_irq, input logic [2:0] exp_vec);
    check({tag, "_irq"}, 8'(bus_if.irq), 8'(exp_irq));
    check({tag, "_vec"}, 8'(bus_if.irq_vector), 8'(exp_vec));
  endtask

  initial begin
    rst = 1'b1;
    bus_if.src = '0; bus_if.din = '0; bus_if.address = '0;
    bus_if.w_en = 1'b0; bus_if.r_en = 1'b0; bus_if.int_ack = 1'b0;
    repeat (3) tick();
    rst = 1'b0;

    // Reset state
    check_irq("reset", 1'b0, 3'd0);
    check("reset_dout", bus_if.dout, 8'h00);
    bus_read(A_PD, rd); check("reset_pending", rd, 8'h00);

    // Basic request
    bus_write(A_EN, 8'h02);
    bus_write(A_CT, 8'h01);
    bus_read(A_EN, rd); check("enable_rd", rd, 8'h02);
    bus_read(A_CT, rd); check("control_rd", rd, 8'h01);
    bus_if.address = A_EN; tick();
    check("dout_hold", bus_if.dout, 8'h01);
    bus_if.src = 8'h02; tick(); bus_if.src = 8'h00;
    check_irq("basic_lat1", 1'b0, 3'd0);
    tick();
    check_irq("basic_req", 1'b1, 3'd1);
    bus_read(A_ST, rd); check("basic_status", rd, 8'h85);
    bus_read(A_PD, rd); check("basic_pending", rd, 8'h02);

    // Ack and EOI
    bus_if.int_ack = 1'b1; tick(); bus_if.int_ack = 1'b0;
    check_irq("ack", 1'b0, 3'd1);
    bus_read(A_PD, rd); check("ack_pending", rd, 8'h00);
    bus_read(A_ST, rd); check("ack_status", rd, 8'h06);
    bus_write(A_EO, 8'h00);
    bus_read(A_ST, rd); check("eoi_status", rd, 8'h04);
    check("eoi_irq", 8'(bus_if.irq), 8'h00);

    // Priority and preemption
    bus_write(A_EN, 8'hFF);
    bus_if.src = 8'h20; tick(); bus_if.src = 8'h00;
    tick();
    check_irq("prio_5", 1'b1, 3'd5);
    bus_if.src = 8'h04; tick(); bus_if.src = 8'h00;
    check_irq("prio_5_hold", 1'b1, 3'd5);
    tick();
    check_irq("prio_2", 1'b1, 3'd2);
    bus_if.int_ack = 1'b1; tick(); bus_if.int_ack = 1'b0;
    check_irq("prio_ack", 1'b0, 3'd2);
    bus_read(A_PD, rd); check("prio_pending", rd, 8'h20);
    bus_write(A_EO, 8'h00);
    check("prio_eoi_idle", 8'(bus_if.irq), 8'h00);
    tick();
    check_irq("prio_rereq", 1'b1, 3'd5);
    bus_if.int_ack = 1'b1; tick(); bus_if.int_ack = 1'b0;
    bus_write(A_EO, 8'h00);

    // Masking and GIE
    bus_write(A_CT, 8'h00);
    bus_if.src = 8'h01; tick(); bus_if.src = 8'h00;
    tick(); tick();
    check("gie_off_irq", 8'(bus_if.irq), 8'h00);
    bus_read(A_PD, rd); check("gie_off_pending", rd, 8'h01);
    bus_write(A_CT, 8'h01);
    tick();
    check_irq("gie_on", 1'b1, 3'd0);
    bus_write(A_PD, 8'h01);
    tick();
    check("w1c_irq", 8'(bus_if.irq), 8'h00);
    bus_read(A_ST, rd); check("w1c_status", rd, 8'h00);

    // Level source and set-vs-clear
    bus_write(A_CT, 8'h00);
    bus_if.src = 8'h08;
    repeat (20) tick();
    bus_read(A_PD, rd); check("level_once", rd, 8'h08);
    bus_write(A_PD, 8'h08);
    bus_read(A_PD, rd); check("level_no_reset", rd, 8'h00);
    bus_if.src = 8'h00; tick();
    bus_if.src = 8'h08;
    bus_write(A_PD, 8'h08);
    bus_read(A_PD, rd); check("set_beats_clear", rd, 8'h08);
    bus_if.src = 8'h00;
    bus_write(A_PD, 8'h08);

    // SWSET, unmapped reads and mid-operation reset
    bus_write(A_EN, 8'h80);
    bus_write(A_CT, 8'h01);
    bus_write(A_SW, 8'h80);
    tick();
    check_irq("swset", 1'b1, 3'd7);
    bus_read(A_SW, rd); check("swset_rd", rd, 8'h00);
    bus_read(A_EN, rd); check("enable_rd2", rd, 8'h80);
    bus_read(A_EO, rd); check("eoi_rd", rd, 8'h00);
    bus_read(8'h20, rd); check("unmapped_rd", rd, 8'h00);
    rst = 1'b1; tick(); rst = 1'b0;
    check_irq("midrst", 1'b0, 3'd0);
    bus_read(A_PD, rd); check("midrst_pending", rd, 8'h00);
    bus_read(A_ST, rd); check("midrst_status", rd, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
